// File: rtl/fixed_to_float.sv
// fixed_to_float
//   Streaming converter from signed two's-complement fixed point to IEEE-754
//   binary32 (FLOAT=1) or binary64 (FLOAT=0), PARALLELISM lanes per beat.
//   Three-stage pipeline (sign/abs, normalize, round/pack) with full
//   valid/ready backpressure and one beat per cycle throughput.
//
// Ports
//   clk       : rising-edge clock
//   rst       : synchronous, active-high reset
//   in_valid  : input beat valid
//   in_ready  : input beat accepted when in_valid && in_ready
//   in_tlast  : last beat of a packet
//   in_mask   : per-lane valid mask; masked lanes produce all-zero results
//   a         : fixed-point operands, signed, FRAC_WIDTH fractional bits
//   out       : float results
//   valid     : output beat valid
//   ready     : downstream ready
//   tlast     : in_tlast of the beat, delayed with its data
//   tkeep     : in_mask of the beat, delayed with its data
module fixed_to_float #(
    parameter int FLOAT       = 1,
    parameter int DATA_WIDTH  = 20,
    parameter int FRAC_WIDTH  = 12,
    parameter int PARALLELISM = 4,
    localparam int OUT_WIDTH  = FLOAT ? 32 : 64
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic                                   in_tlast,
    input  logic [PARALLELISM-1:0]                 in_mask,
    input  logic [PARALLELISM-1:0][DATA_WIDTH-1:0] a,
    output logic [PARALLELISM-1:0][OUT_WIDTH-1:0]  out,
    output logic                                   valid,
    input  logic                                   ready,
    output logic                                   tlast,
    output logic [PARALLELISM-1:0]                 tkeep
);

    localparam int MANT_W = FLOAT ? 23 : 52;
    localparam int EXP_W  = FLOAT ? 8 : 11;
    localparam int BIAS   = FLOAT ? 127 : 1023;
    // Normalized magnitude placed at the top, with room below for the
    // mantissa, the guard bit and at least one sticky bit.
    localparam int EXT_W  = DATA_WIDTH + MANT_W + 2;

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    logic v1, v2, v3;
    logic load1, load2, load3;

    assign load3    = !v3 || ready;
    assign load2    = !v2 || load3;
    assign load1    = !v1 || load2;
    assign in_ready = !rst && load1;
    assign valid    = v3;

    // ------------------------------------------------------------------
    // Stage 1: sign and magnitude
    // ------------------------------------------------------------------
    logic                                   last1;
    logic [PARALLELISM-1:0]                 keep1;
    logic [PARALLELISM-1:0]                 sign1;
    logic [PARALLELISM-1:0][DATA_WIDTH-1:0] mag1;
    logic [PARALLELISM-1:0][DATA_WIDTH-1:0] mag_n;

    // Unsigned magnitude: the most-negative input maps to 2^(DATA_WIDTH-1).
    always_comb begin
        for (int unsigned i = 0; i < PARALLELISM; i++) begin
            mag_n[i] = a[i][DATA_WIDTH-1] ? -a[i] : a[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1    <= 1'b0;
            last1 <= 1'b0;
            keep1 <= '0;
            sign1 <= '0;
            mag1  <= '0;
        end else if (load1) begin
            v1    <= in_valid;
            last1 <= in_tlast;
            keep1 <= in_mask;
            // A masked lane becomes a zero magnitude, which packs as +0.0.
            for (int unsigned i = 0; i < PARALLELISM; i++) begin
                sign1[i] <= in_mask[i] & a[i][DATA_WIDTH-1];
                mag1[i]  <= in_mask[i] ? mag_n[i] : '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: leading-one detect and normalize
    // ------------------------------------------------------------------
    logic                                   last2;
    logic [PARALLELISM-1:0]                 keep2;
    logic [PARALLELISM-1:0]                 sign2;
    logic [PARALLELISM-1:0][DATA_WIDTH-1:0] norm2;
    logic [PARALLELISM-1:0][EXP_W-1:0]      exp2;
    logic [PARALLELISM-1:0][DATA_WIDTH-1:0] norm_n;
    logic [PARALLELISM-1:0][EXP_W-1:0]      exp_n;

    always_comb begin
        logic [6:0] p;
        for (int unsigned i = 0; i < PARALLELISM; i++) begin
            p = '0;
            for (int unsigned j = 0; j < DATA_WIDTH; j++) begin
                if (mag1[i][j]) p = 7'(j);
            end
            norm_n[i] = mag1[i] << (7'(DATA_WIDTH - 1) - p);
            // Biased exponent; always in the normal range for legal widths.
            exp_n[i]  = EXP_W'(int'(p) - FRAC_WIDTH + BIAS);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2    <= 1'b0;
            last2 <= 1'b0;
            keep2 <= '0;
            sign2 <= '0;
            norm2 <= '0;
            exp2  <= '0;
        end else if (load2) begin
            v2    <= v1;
            last2 <= last1;
            keep2 <= keep1;
            sign2 <= sign1;
            norm2 <= norm_n;
            exp2  <= exp_n;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: round to nearest even and pack
    // ------------------------------------------------------------------
    logic [PARALLELISM-1:0][OUT_WIDTH-1:0] res_n;

    always_comb begin
        logic [EXT_W-1:0]  ext;
        logic [MANT_W-1:0] mant;
        logic              guard;
        logic              sticky;
        logic              round_up;
        logic [MANT_W:0]   sum;
        logic [EXP_W-1:0]  exp_f;
        for (int unsigned i = 0; i < PARALLELISM; i++) begin
            ext = '0;
            ext[EXT_W-1 -: DATA_WIDTH] = norm2[i];
            mant     = ext[EXT_W-2 -: MANT_W];
            guard    = ext[EXT_W-2-MANT_W];
            // Round and sticky folded together: any set bit below guard.
            sticky   = |ext[EXT_W-3-MANT_W:0];
            round_up = guard & (sticky | mant[0]);
            sum      = {1'b0, mant} + (MANT_W+1)'(round_up);
            // Carry-out leaves the mantissa bits zero; bump the exponent.
            exp_f    = exp2[i] + EXP_W'(sum[MANT_W]);
            // Top bit of a normalized value is clear only for zero.
            res_n[i] = ext[EXT_W-1] ? {sign2[i], exp_f, sum[MANT_W-1:0]} : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v3    <= 1'b0;
            tlast <= 1'b0;
            tkeep <= '0;
            out   <= '0;
        end else if (load3) begin
            v3    <= v2;
            tlast <= last2;
            tkeep <= keep2;
            out   <= res_n;
        end
    end

endmodule

// File: tb/tb_fixed_to_float.sv
module tb_fixed_to_float;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_tlast, ready;
    logic [3:0] in_mask;
    logic [3:0][19:0] a;
    logic [3:0][31:0] ar;

    logic in_ready, valid, tlast;
    logic [3:0] tkeep;
    logic [3:0][31:0] out0;
    logic r_in_ready, r_valid, r_tlast;
    logic [3:0] r_tkeep;
    logic [3:0][31:0] out1;
    logic d_in_ready, d_valid, d_tlast;
    logic [3:0] d_tkeep;
    logic [3:0][63:0] out2;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Main: binary32, Q7.12 input
    fixed_to_float #(.FLOAT(1), .DATA_WIDTH(20), .FRAC_WIDTH(12), .PARALLELISM(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_tlast(in_tlast), .in_mask(in_mask), .a(a), .out(out0),
        .valid(valid), .ready(ready), .tlast(tlast), .tkeep(tkeep));

    // Rounding: binary32, 32-bit integer input
    fixed_to_float #(.FLOAT(1), .DATA_WIDTH(32), .FRAC_WIDTH(0), .PARALLELISM(4)) dut_round (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r_in_ready),
        .in_tlast(in_tlast), .in_mask(in_mask), .a(ar), .out(out1),
        .valid(r_valid), .ready(ready), .tlast(r_tlast), .tkeep(r_tkeep));

    // Double: binary64, Q7.12 input
    fixed_to_float #(.FLOAT(0), .DATA_WIDTH(20), .FRAC_WIDTH(12), .PARALLELISM(4)) dut_double (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_in_ready),
        .in_tlast(in_tlast), .in_mask(in_mask), .a(a), .out(out2),
        .valid(d_valid), .ready(ready), .tlast(d_tlast), .tkeep(d_tkeep));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: value = v / 2^fw rounded to binary32 (nearest, ties to even)
    function automatic logic [31:0] ref_f32(input longint v, input int fw);
        longint unsigned mag, q, rem, half;
        int k;
        logic s;
        if (v == 0) return 32'h0;
        s = (v < 0);
        mag = s ? longint'(-v) : longint'(v);
        k = 0;
        while ((mag >> (k + 1)) != 0) k++;
        if (k <= 23) begin
            q = mag << (23 - k);
        end else begin
            q = mag >> (k - 23);
            rem = mag - (q << (k - 23));
            half = 64'd1 << (k - 24);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                k++;
            end
        end
        return {s, 8'(k - fw + 127), 23'(q)};
    endfunction

    // Reference: binary64 via the simulator's own real type (exact for 20 bits)
    function automatic logic [63:0] ref_f64(input longint v, input int fw);
        real r;
        r = v;
        for (int i = 0; i < fw; i++) r = r / 2.0;
        return $realtobits(r);
    endfunction

    typedef struct {
        logic [3:0][31:0] e0;
        logic [3:0][31:0] e1;
        logic [3:0][63:0] e2;
        logic             last;
        logic [3:0]       keep;
        int               acc;
    } exp_t;

    exp_t sb[$];

    logic rst_seen = 1'b0;
    logic hold_prev = 1'b0;
    logic [3:0][31:0] p_out0, p_out1;
    logic [3:0][63:0] p_out2;
    logic p_tlast;
    logic [3:0] p_tkeep;

    always @(negedge clk) begin
        exp_t e;
        logic exp_ir, exp_v;
        if (rst) begin
            check("rst_in_ready", {r_in_ready, d_in_ready, in_ready}, 3'b000);
            sb.delete();
        end
        if (rst_seen) begin
            check("rst_valid", {r_valid, d_valid, valid}, 3'b000);
            check("rst_tlast", {r_tlast, d_tlast, tlast}, 3'b000);
            check("rst_tkeep", {r_tkeep, d_tkeep, tkeep}, 12'h000);
            for (int i = 0; i < 4; i++) begin
                check($sformatf("rst_out0[%0d]", i), out0[i], 64'h0);
                check($sformatf("rst_out2[%0d]", i), out2[i], 64'h0);
            end
        end
        if (!rst) begin
            exp_ir = ready || (sb.size() < 3);
            check("in_ready", in_ready, exp_ir);
            check("r_in_ready", r_in_ready, exp_ir);
            check("d_in_ready", d_in_ready, exp_ir);
            exp_v = (sb.size() > 0) && (cyc >= sb[0].acc + 3);
            check("valid", valid, exp_v);
            check("r_valid", r_valid, exp_v);
            check("d_valid", d_valid, exp_v);
            if (hold_prev) begin
                check("stall_out0", out0, p_out0);
                check("stall_out1", out1, p_out1);
                check("stall_out2_lo", out2[1:0], p_out2[1:0]);
                check("stall_out2_hi", out2[3:2], p_out2[3:2]);
                check("stall_side", {tlast, tkeep}, {p_tlast, p_tkeep});
            end
            if (valid && ready && sb.size() > 0) begin
                e = sb.pop_front();
                check("tlast", {r_tlast, d_tlast, tlast}, {3{e.last}});
                check("tkeep", {r_tkeep, d_tkeep, tkeep}, {3{e.keep}});
                for (int i = 0; i < 4; i++) begin
                    check($sformatf("f32[%0d]", i), out0[i], e.e0[i]);
                    check($sformatf("rnd[%0d]", i), out1[i], e.e1[i]);
                    check($sformatf("f64[%0d]", i), out2[i], e.e2[i]);
                end
            end
            if (in_valid && in_ready) begin
                for (int i = 0; i < 4; i++) begin
                    e.e0[i] = in_mask[i] ? ref_f32(longint'($signed(a[i])), 12) : 32'h0;
                    e.e1[i] = in_mask[i] ? ref_f32(longint'($signed(ar[i])), 0) : 32'h0;
                    e.e2[i] = in_mask[i] ? ref_f64(longint'($signed(a[i])), 12) : 64'h0;
                end
                e.last = in_tlast;
                e.keep = in_mask;
                e.acc = cyc;
                sb.push_back(e);
            end
        end
        hold_prev = !rst && valid && !ready;
        p_out0 = out0;
        p_out1 = out1;
        p_out2 = out2;
        p_tlast = tlast;
        p_tkeep = tkeep;
        rst_seen = rst;
    end

    // Driver tasks: entered and left at posedge + 1
    task automatic send(input logic [3:0][19:0] av, input logic [3:0][31:0] arv,
                        input logic [3:0] m, input logic l);
        int n;
        in_valid = 1'b1;
        a = av;
        ar = arv;
        in_mask = m;
        in_tlast = l;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_tlast = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] rand20();
        case ($urandom_range(0, 5))
            0: return 20'h00000;
            1: return 20'h80000;
            2: return 20'h7FFFF;
            3: return 20'hFFFFF;
            4: return 20'(32'd1 << $urandom_range(0, 19));
            default: return 20'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] rand32();
        case ($urandom_range(0, 5))
            0: return 32'h00000000;
            1: return 32'h80000000;
            2: return 32'h7FFFFFFF;
            3: return ($urandom & 32'hFFFFFF00) | 32'h00000080;
            4: return 32'h01000000 | ($urandom & 32'h00FFFFFF);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0][19:0] av;
        logic [3:0][31:0] arv;
        bit done;
        int n;
        rst = 1'b1;
        in_valid = 1'b0;
        in_tlast = 1'b0;
        in_mask = 4'h0;
        a = '0;
        ar = '0;
        ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic conversions and rounding cases, one beat
        send({20'h00000, 20'h80000, 20'hFF000, 20'h01000},
             {32'h80000000, 32'h01FFFFFF, 32'h01000003, 32'h01000001}, 4'hF, 1'b1);
        idle(5);
        // Double precision values
        send({20'hFFFFF, 20'h7FFFF, 20'h00800, 20'h01000},
             {32'h00FFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h7FFFFFFF}, 4'hF, 1'b0);
        idle(5);
        // Mask
        send({4{20'h01000}}, {4{32'h01000001}}, 4'b0101, 1'b1);
        idle(5);

        // Backpressure: 8 back-to-back beats, ready low for cycles 4..8
        fork
            begin
                for (int b = 1; b <= 8; b++) begin
                    for (int i = 0; i < 4; i++) begin
                        av[i] = 20'(b * 4096 + i * 333);
                        arv[i] = 32'(b * 32'h01000001 + i);
                    end
                    av[3] = -av[3];
                    send(av, arv, 4'hF, b == 8);
                end
                idle(1);
            end
            begin
                for (int c = 1; c <= 12; c++) begin
                    ready = !(c >= 4 && c <= 8);
                    @(posedge clk);
                    #1;
                end
                ready = 1'b1;
            end
        join
        idle(10);

        // Reset mid-stream with 3 beats held in the pipeline
        ready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            av = {4{20'(20'h00100 << b)}};
            arv = {4{32'(32'h12345678 + b)}};
            send(av, arv, 4'hF, b == 2);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ready = 1'b1;
        idle(6);
        send({20'h00800, 20'hFF800, 20'h03000, 20'h01000},
             {32'h01000003, 32'h01000001, 32'hFFFFFFFF, 32'h00000005}, 4'hF, 1'b1);
        idle(6);

        // Randomized traffic with random backpressure
        done = 1'b0;
        fork
            begin
                for (int b = 0; b < 300; b++) begin
                    for (int i = 0; i < 4; i++) begin
                        av[i] = rand20();
                        arv[i] = rand32();
                    end
                    send(av, arv, 4'($urandom), 1'($urandom));
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                end
                idle(1);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                ready = 1'b1;
            end
        join

        n = 0;
        while (sb.size() > 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", 64'(sb.size()), 64'd0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
